// File: rtl/st7789_spi_tx.sv
// ST7789 SPI mode-0 serializer fed from a first-word-fall-through FIFO.
// USER[0] drives D/C, KEEP masks bytes, LAST closes the chip-select frame.
module st7789_spi_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [DATA_WIDTH-1:0]   IN_DOUT_DATA,
  input  logic [DATA_WIDTH/8-1:0] IN_DOUT_KEEP,
  input  logic [USER_WIDTH-1:0]   IN_DOUT_USER,
  input  logic                    IN_DOUT_LAST,
  input  logic                    IN_EMPTY,
  output logic                    IN_RDEN,
  output logic                    SPI_SCLK,
  output logic                    SPI_MOSI,
  output logic                    SPI_CS_N,
  output logic                    SPI_DC,
  output logic                    BUSY
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int DIVW = $clog2(CLK_DIV + 1);
  localparam int GW   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [NB-1:0]           keep_q;
  logic                    last_q;
  logic [BW-1:0]           byte_q;
  logic [2:0]              bit_q;
  logic                    phase_q;
  logic [DIVW-1:0]         div_q;
  logic [GW-1:0]           gap_q;
  logic                    pop_q;
  logic                    sclk_q;
  logic                    mosi_q;
  logic                    cs_n_q;
  logic                    dc_q;
  logic                    busy_q;

  logic                    acc_ok_d;
  logic                    rden_d;
  logic [NB-1:0]           rem_d;
  logic [BW-1:0]           first_d;

  function automatic logic [BW-1:0] top_byte(
    input logic [NB-1:0] k
  );
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      if (k[i]) r = BW'(i);
    end
    return r;
  endfunction

  function automatic logic bit_at(
    input logic [DATA_WIDTH-1:0] d,
    input logic [BW-1:0]         b,
    input logic [2:0]            t
  );
    logic [DATA_WIDTH-1:0] s;
    s = d >> {b, t};
    return s[0];
  endfunction

  // pop_q blocks back-to-back pops after a zero-KEEP word
  assign acc_ok_d = (state_q == S_IDLE || state_q == S_FETCH ||
                     state_q == S_WAIT) && !pop_q;
  assign rden_d   = !RESET && acc_ok_d && !IN_EMPTY;
  assign rem_d    = keep_q & ~(NB'(1) << byte_q);
  assign first_d  = top_byte(IN_DOUT_KEEP);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      byte_q  <= '0;
      bit_q   <= 3'd7;
      phase_q <= 1'b0;
      div_q   <= '0;
      gap_q   <= '0;
      pop_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pop_q <= rden_d;
      if (rden_d) begin
        data_q <= IN_DOUT_DATA;
        keep_q <= IN_DOUT_KEEP;
        last_q <= IN_DOUT_LAST;
        if (|IN_DOUT_KEEP) begin
          state_q <= S_SHIFT;
          byte_q  <= first_d;
          bit_q   <= 3'd7;
          phase_q <= 1'b0;
          mosi_q  <= bit_at(IN_DOUT_DATA, first_d, 3'd7);
          dc_q    <= IN_DOUT_USER[0];
          cs_n_q  <= 1'b0;
          sclk_q  <= 1'b0;
          busy_q  <= 1'b1;
          // a new frame gets one extra CS-setup cycle
          div_q   <= (state_q == S_IDLE) ? DIVW'(CLK_DIV)
                                          : DIVW'(CLK_DIV - 1);
        end else if (IN_DOUT_LAST && !cs_n_q) begin
          state_q <= S_HOLD;
          div_q   <= DIVW'(CLK_DIV - 1);
        end else if (!cs_n_q) begin
          state_q <= S_WAIT;
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
          end
          S_WAIT: begin
          end
          S_FETCH: begin
            state_q <= S_WAIT;
          end
          S_SHIFT: begin
            if (div_q != '0) begin
              div_q <= div_q - 1'b1;
            end else if (!phase_q) begin
              sclk_q  <= 1'b1;
              phase_q <= 1'b1;
              div_q   <= DIVW'(CLK_DIV - 1);
            end else begin
              sclk_q  <= 1'b0;
              phase_q <= 1'b0;
              div_q   <= DIVW'(CLK_DIV - 1);
              if (bit_q != 3'd0) begin
                bit_q  <= bit_q - 3'd1;
                mosi_q <= bit_at(data_q, byte_q, bit_q - 3'd1);
              end else if (|rem_d) begin
                keep_q <= rem_d;
                byte_q <= top_byte(rem_d);
                bit_q  <= 3'd7;
                mosi_q <= bit_at(data_q, top_byte(rem_d), 3'd7);
              end else if (last_q) begin
                state_q <= S_HOLD;
              end else begin
                state_q <= S_FETCH;
              end
            end
          end
          S_HOLD: begin
            if (div_q != '0) begin
              div_q <= div_q - 1'b1;
            end else begin
              cs_n_q <= 1'b1;
              // the IDLE accept cycle completes the CS-high gap
              if (CS_GAP > 1) begin
                state_q <= S_GAP;
                gap_q   <= GW'(CS_GAP - 2);
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          S_GAP: begin
            if (gap_q != '0) begin
              gap_q <= gap_q - 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign IN_RDEN  = rden_d;
  assign SPI_SCLK = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS_N = cs_n_q;
  assign SPI_DC   = dc_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_st7789_spi_tx.sv
// Bench for st7789_spi_tx: FIFO model, byte scoreboard, frame timing.
// Vector table for single-word frames plus hand-written corner sequences.
module tb_st7789_spi_tx;

  localparam int CLK_DIV = 1;
  localparam int CS_GAP  = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] IN_DOUT_DATA;
  logic [1:0]  IN_DOUT_KEEP;
  logic [0:0]  IN_DOUT_USER;
  logic        IN_DOUT_LAST;
  logic        IN_EMPTY;
  logic        IN_RDEN;
  logic        SPI_SCLK;
  logic        SPI_MOSI;
  logic        SPI_CS_N;
  logic        SPI_DC;
  logic        BUSY;

  st7789_spi_tx #(
    .DATA_WIDTH(16),
    .USER_WIDTH(1),
    .CLK_DIV(CLK_DIV),
    .CS_GAP(CS_GAP)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .IN_DOUT_DATA(IN_DOUT_DATA),
    .IN_DOUT_KEEP(IN_DOUT_KEEP),
    .IN_DOUT_USER(IN_DOUT_USER),
    .IN_DOUT_LAST(IN_DOUT_LAST),
    .IN_EMPTY(IN_EMPTY),
    .IN_RDEN(IN_RDEN),
    .SPI_SCLK(SPI_SCLK),
    .SPI_MOSI(SPI_MOSI),
    .SPI_CS_N(SPI_CS_N),
    .SPI_DC(SPI_DC),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        u;
    logic        l;
  } word_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    logic        u;
    int          frames;
    int          low;
    int          rises;
  } vec_t;

  word_t      fifo[$];
  logic [8:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int   cyc = 0;
  int   rises = 0;
  int   frames = 0;
  int   rden_cnt = 0;
  int   viol = 0;
  int   dc_glitch = 0;
  int   cur_low = 0;
  int   cur_high = 0;
  int   last_low_len = 0;
  int   last_high_len = 0;
  int   gap_run = 0;
  int   last_gap = 0;
  int   bitn = 0;
  logic [7:0] sh = 8'h00;
  logic dc_b = 1'b0;
  logic prev_sclk = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_rden = 1'b0;
  logic prev_busy = 1'b0;
  logic pop_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_head();
    if (fifo.size() == 0) begin
      IN_EMPTY     = 1'b1;
      IN_DOUT_DATA = 16'h0000;
      IN_DOUT_KEEP = 2'b00;
      IN_DOUT_USER = 1'b0;
      IN_DOUT_LAST = 1'b0;
    end else begin
      IN_EMPTY     = 1'b0;
      IN_DOUT_DATA = fifo[0].d;
      IN_DOUT_KEEP = fifo[0].k;
      IN_DOUT_USER = fifo[0].u;
      IN_DOUT_LAST = fifo[0].l;
    end
  endtask

  task automatic push_word(input logic [15:0] d, input logic [1:0] k,
                           input logic u, input logic l);
    word_t w;
    w = '{d: d, k: k, u: u, l: l};
    fifo.push_back(w);
    for (int b = 1; b >= 0; b--) begin
      if (k[b]) exp_q.push_back({u, d[8*b +: 8]});
    end
    drive_head();
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!BUSY && fifo.size() == 0 && !IN_RDEN) begin
        done = 1'b1;
        break;
      end
    end
    check("idle_reached", {31'd0, done}, 32'd1);
  endtask

  // FIFO pop lands just after the edge that consumed the head
  always @(posedge CLK) begin
    if (pop_req) begin
      #1;
      if (fifo.size() > 0) fifo.delete(0);
      pop_req = 1'b0;
      drive_head();
    end
  end

  always @(negedge CLK) begin
    cyc++;
    pop_req = IN_RDEN;
    if (IN_RDEN) rden_cnt++;
    if (IN_RDEN && (IN_EMPTY || prev_rden)) viol++;
    if (SPI_SCLK && !prev_sclk) rises++;
    if (SPI_CS_N) begin
      bitn = 0;
    end else if (SPI_SCLK && !prev_sclk) begin
      if (bitn == 0) dc_b = SPI_DC;
      else if (SPI_DC != dc_b) dc_glitch++;
      sh = {sh[6:0], SPI_MOSI};
      bitn++;
      if (bitn == 8) begin
        bitn = 0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL byte_unexpected: got %0h want none", {dc_b, sh});
        end else begin
          check("byte", {23'd0, dc_b, sh}, {23'd0, exp_q[0]});
          exp_q.delete(0);
        end
      end
    end
    if (!SPI_CS_N) begin
      if (prev_cs) last_high_len = cur_high;
      cur_low = prev_cs ? 1 : cur_low + 1;
      gap_run = 0;
    end else begin
      if (!prev_cs) begin
        last_low_len = cur_low;
        frames++;
      end
      cur_high = !prev_cs ? 1 : cur_high + 1;
      if (BUSY) gap_run++;
    end
    if (!BUSY && prev_busy) begin
      last_gap = gap_run + 1;
      gap_run = 0;
    end
    prev_sclk = SPI_SCLK;
    prev_cs   = SPI_CS_N;
    prev_rden = IN_RDEN;
    prev_busy = BUSY;
  end

  vec_t vt[6];

  initial begin
    int f0, r0, p0, t0;
    logic hit;

    vt[0] = '{16'h2A5C, 2'b11, 1'b0, 1, 34, 16};
    vt[1] = '{16'hABCD, 2'b10, 1'b0, 1, 18, 8};
    vt[2] = '{16'h1234, 2'b01, 1'b1, 1, 18, 8};
    vt[3] = '{16'hFFFF, 2'b11, 1'b1, 1, 34, 16};
    vt[4] = '{16'h0000, 2'b11, 1'b0, 1, 34, 16};
    vt[5] = '{16'h5A5A, 2'b00, 1'b0, 0, 0, 0};

    RESET = 1'b1;
    drive_head();
    repeat (3) tick();
    check("reset_outs",
          {26'd0, IN_RDEN, SPI_SCLK, SPI_MOSI, SPI_CS_N, SPI_DC, BUSY},
          32'b000100);
    @(posedge CLK);
    #2 RESET = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) begin
      f0 = frames;
      r0 = rises;
      p0 = rden_cnt;
      @(posedge CLK);
      #2 push_word(vt[i].d, vt[i].k, vt[i].u, 1'b1);
      wait_idle(200);
      check("vec_frames", frames - f0, vt[i].frames);
      check("vec_rises", rises - r0, vt[i].rises);
      check("vec_pops", rden_cnt - p0, 1);
      if (vt[i].frames != 0) begin
        check("vec_cs_low", last_low_len, vt[i].low);
        check("vec_gap_busy", last_gap, CS_GAP);
      end
    end

    // command then three pixel words, all preloaded
    f0 = frames;
    r0 = rises;
    @(posedge CLK);
    #2;
    push_word(16'h002C, 2'b01, 1'b0, 1'b0);
    push_word(16'hF800, 2'b11, 1'b1, 1'b0);
    push_word(16'hF800, 2'b11, 1'b1, 1'b0);
    push_word(16'hF800, 2'b11, 1'b1, 1'b1);
    wait_idle(400);
    check("cmd_frames", frames - f0, 1);
    check("cmd_cs_low", last_low_len, 117);
    check("cmd_rises", rises - r0, 56);

    // zero-KEEP LAST word closes an open frame
    f0 = frames;
    r0 = rises;
    @(posedge CLK);
    #2;
    push_word(16'h1234, 2'b11, 1'b1, 1'b0);
    push_word(16'h9999, 2'b00, 1'b0, 1'b1);
    wait_idle(200);
    check("zk_frames", frames - f0, 1);
    check("zk_cs_low", last_low_len, 35);
    check("zk_rises", rises - r0, 16);

    // FIFO starves mid-frame
    f0 = frames;
    r0 = rises;
    p0 = rden_cnt;
    @(posedge CLK);
    #2 push_word(16'hC3A5, 2'b11, 1'b1, 1'b0);
    repeat (85) tick();
    check("stall_cs", {31'd0, SPI_CS_N}, 0);
    check("stall_sclk", {31'd0, SPI_SCLK}, 0);
    check("stall_busy", {31'd0, BUSY}, 1);
    check("stall_rises", rises - r0, 16);
    check("stall_pops", rden_cnt - p0, 1);
    @(posedge CLK);
    #2 push_word(16'h7E81, 2'b11, 1'b1, 1'b1);
    hit = 1'b0;
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (IN_RDEN) begin
        hit = 1'b1;
        t0 = cyc;
        break;
      end
    end
    check("stall_pop_seen", {31'd0, hit}, 1);
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (SPI_SCLK) begin
        hit = 1'b1;
        break;
      end
    end
    check("stall_resume", hit ? cyc - t0 : -1, 2);
    wait_idle(200);
    check("stall_frames", frames - f0, 1);

    // reset in the middle of a byte
    r0 = rises;
    @(posedge CLK);
    #2 push_word(16'hB6D9, 2'b11, 1'b0, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rises - r0 == 2) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reach_bit", {31'd0, hit}, 1);
    @(posedge CLK);
    #2 RESET = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #2 push_word(16'h3C00, 2'b10, 1'b1, 1'b1);
    tick();
    check("rst_outs", {28'd0, SPI_CS_N, SPI_SCLK, BUSY, IN_RDEN},
          32'b1000);
    @(posedge CLK);
    #2 RESET = 1'b0;
    tick();
    check("rst_pop_now", {31'd0, IN_RDEN}, 1);
    wait_idle(200);

    // back-to-back frames
    f0 = frames;
    @(posedge CLK);
    #2;
    push_word(16'h00A1, 2'b01, 1'b0, 1'b1);
    push_word(16'h005F, 2'b01, 1'b1, 1'b1);
    wait_idle(200);
    check("b2b_frames", frames - f0, 2);
    check("b2b_cs_gap", last_high_len, CS_GAP);

    check("rden_rules", viol, 0);
    check("dc_stable", dc_glitch, 0);
    check("exp_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
